// File: rtl/ex_mem_wb_regs.sv
// ex_mem_wb_regs: EX/MEM and MEM/WB pipeline registers with write-back select,
// sticky halt tracking and a retired-instruction counter.
module ex_mem_wb_regs #(
    parameter int BUS_SIZE      = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int CNT_SIZE      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_wb,
    input  logic                     i_ex_mem_to_reg,
    input  logic                     i_ex_mem_rd,
    input  logic                     i_ex_mem_wr,
    input  logic                     i_ex_halt,
    input  logic [MEM_ADDR_SIZE-1:0] i_ex_addr,
    input  logic [BUS_SIZE-1:0]      i_ex_alu_result,
    input  logic [BUS_SIZE-1:0]      i_ex_store_data,
    input  logic [BUS_SIZE-1:0]      i_mem_rd_data,
    output logic                     o_ex_mem_wb,
    output logic                     o_ex_mem_mem_rd,
    output logic                     o_ex_mem_mem_wr,
    output logic [MEM_ADDR_SIZE-1:0] o_ex_mem_addr,
    output logic [BUS_SIZE-1:0]      o_ex_mem_alu_result,
    output logic [BUS_SIZE-1:0]      o_ex_mem_store_data,
    output logic                     o_mem_wb_wb,
    output logic [MEM_ADDR_SIZE-1:0] o_mem_wb_addr,
    output logic [BUS_SIZE-1:0]      o_mem_wb_data,
    output logic                     o_halted,
    output logic [CNT_SIZE-1:0]      o_retired
);
    logic adv, bubble;
    logic em_valid_d, em_valid_q, em_wb_d, em_wb_q, em_m2r_d, em_m2r_q;
    logic em_rd_d, em_rd_q, em_wr_d, em_wr_q, em_halt_d, em_halt_q;
    logic [MEM_ADDR_SIZE-1:0] em_addr_d, em_addr_q, mw_addr_d, mw_addr_q;
    logic [BUS_SIZE-1:0] em_alu_d, em_alu_q, em_st_d, em_st_q, mw_data_d, mw_data_q;
    logic mw_wb_d, mw_wb_q, halted_d, halted_q;
    logic [CNT_SIZE-1:0] retired_d, retired_q;

    // MEM/WB valid and halt are folded into the retired counter and halted flag
    always_comb begin
        adv        = i_enable & ~halted_q;
        bubble     = i_flush | ~i_ex_valid;
        em_valid_d = adv ? ~bubble : em_valid_q;
        em_wb_d    = adv ? ~bubble & i_ex_wb & (i_ex_addr != '0) : em_wb_q;
        em_m2r_d   = adv ? ~bubble & i_ex_mem_to_reg : em_m2r_q;
        em_rd_d    = adv ? ~bubble & i_ex_mem_rd : em_rd_q;
        em_wr_d    = adv ? ~bubble & i_ex_mem_wr : em_wr_q;
        em_halt_d  = adv ? ~bubble & i_ex_halt : em_halt_q;
        em_addr_d  = adv ? (bubble ? '0 : i_ex_addr) : em_addr_q;
        em_alu_d   = adv ? (bubble ? '0 : i_ex_alu_result) : em_alu_q;
        em_st_d    = adv ? (bubble ? '0 : i_ex_store_data) : em_st_q;
        mw_wb_d    = adv ? em_wb_q : mw_wb_q;
        mw_addr_d  = adv ? em_addr_q : mw_addr_q;
        mw_data_d  = adv ? (em_m2r_q ? i_mem_rd_data : em_alu_q) : mw_data_q;
        halted_d   = halted_q | (adv & em_halt_q);
        retired_d  = retired_q + CNT_SIZE'(adv & em_valid_q);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            em_valid_q <= 1'b0;
            em_wb_q    <= 1'b0;
            em_m2r_q   <= 1'b0;
            em_rd_q    <= 1'b0;
            em_wr_q    <= 1'b0;
            em_halt_q  <= 1'b0;
            em_addr_q  <= '0;
            em_alu_q   <= '0;
            em_st_q    <= '0;
            mw_wb_q    <= 1'b0;
            mw_addr_q  <= '0;
            mw_data_q  <= '0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            em_valid_q <= em_valid_d;
            em_wb_q    <= em_wb_d;
            em_m2r_q   <= em_m2r_d;
            em_rd_q    <= em_rd_d;
            em_wr_q    <= em_wr_d;
            em_halt_q  <= em_halt_d;
            em_addr_q  <= em_addr_d;
            em_alu_q   <= em_alu_d;
            em_st_q    <= em_st_d;
            mw_wb_q    <= mw_wb_d;
            mw_addr_q  <= mw_addr_d;
            mw_data_q  <= mw_data_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    assign o_ex_mem_wb         = em_wb_q;
    assign o_ex_mem_mem_rd     = em_rd_q;
    assign o_ex_mem_mem_wr     = em_wr_q;
    assign o_ex_mem_addr       = em_addr_q;
    assign o_ex_mem_alu_result = em_alu_q;
    assign o_ex_mem_store_data = em_st_q;
    assign o_mem_wb_wb         = mw_wb_q;
    assign o_mem_wb_addr       = mw_addr_q;
    assign o_mem_wb_data       = mw_data_q;
    assign o_halted            = halted_q;
    assign o_retired           = retired_q;
endmodule

// File: doc/ex_mem_wb_regs.md
# ex_mem_wb_regs

Pipeline register chain covering EX/MEM and MEM/WB. It captures execute-stage results and write-back control, presents them to data memory, and selects the write-back value. It is the direct producer of `o_ex_mem_wb`, `o_ex_mem_addr`, `o_mem_wb_wb` and `o_mem_wb_addr`, which feed the forwarding unit's `i_ex_mem_*` and `i_mem_wb_*` inputs. It also tracks halt propagation and counts retired instructions for the debug unit.

## Interface
- `BUS_SIZE`, 32, datapath width
- `MEM_ADDR_SIZE`, 5, register-file address width
- `CNT_SIZE`, 16, retired-instruction counter width
- `i_clk`  in  1  clock, rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_enable`  in  1  pipeline advance enable (debug step/run)
- `i_flush`  in  1  replace the incoming EX bundle with a bubble
- `i_ex_valid`  in  1  EX holds a real instruction
- `i_ex_wb`  in  1  instruction writes the register file
- `i_ex_mem_to_reg`  in  1  write-back source is memory read data
- `i_ex_mem_rd`, `i_ex_mem_wr`  in  1 each  data-memory read/write request
- `i_ex_halt`  in  1  instruction is HALT
- `i_ex_addr`  in  MEM_ADDR_SIZE  destination register
- `i_ex_alu_result`, `i_ex_store_data`  in  BUS_SIZE  ALU output, store operand
- `i_mem_rd_data`  in  BUS_SIZE  combinational data-memory read for the EX/MEM entry
- `o_ex_mem_wb`, `o_ex_mem_mem_rd`, `o_ex_mem_mem_wr`  out  1  EX/MEM controls
- `o_ex_mem_addr`  out  MEM_ADDR_SIZE  EX/MEM destination
- `o_ex_mem_alu_result`, `o_ex_mem_store_data`  out  BUS_SIZE
- `o_mem_wb_wb`  out  1  MEM/WB register-file write enable
- `o_mem_wb_addr`  out  MEM_ADDR_SIZE
- `o_mem_wb_data`  out  BUS_SIZE  selected write-back value
- `o_halted`  out  1  sticky; HALT has retired
- `o_retired`  out  CNT_SIZE  valid instructions retired since reset

## Operation
- Two register stages, EX/MEM and MEM/WB. Each has a valid bit and carries the fields above.
- **Advance condition:** `adv = i_enable & ~o_halted`. Both stages update only when `adv` is high; otherwise all state holds.
- **EX/MEM load on `adv`:**
  - If `i_flush` or `~i_ex_valid`, load a bubble: valid=0, wb=0, mem_rd=0, mem_wr=0, halt=0, addr=0, data fields=0.
  - Otherwise load the EX fields.
- **Register-0 write suppression:** `wb` is stored as `i_ex_wb & (i_ex_addr != 0)`, so no output ever asserts a write to r0.
- **MEM/WB load on `adv`:**
  - Copies valid, wb, addr and halt from EX/MEM.
  - Stores the data field as `i_mem_rd_data` when EX/MEM mem_to_reg=1, else EX/MEM alu_result.
- `o_mem_wb_data` is the registered data; no combinational path from inputs.
- **Halt:** when a MEM/WB load captures halt=1, `o_halted` sets on that edge and stays set until reset. The pipeline then freezes; instructions behind HALT are never retired.
- **Retired counter:** `o_retired` increments on each `adv` edge where MEM/WB loads valid=1, HALT included. It wraps at 2^CNT_SIZE to 0.
- **Simultaneous `i_flush` and `i_ex_halt`:** flush wins, and the HALT is discarded.

## Timing
- **Reset (async assert, sync release):** every output and internal register is 0, including `o_halted` and `o_retired`.
- Reset mid-operation discards all in-flight entries immediately.
- **EX → EX/MEM outputs:** 1 cycle with `adv` high.
- **EX → MEM/WB outputs:** 2 cycles with `adv` high.
- **HALT accepted at EX on edge N with `adv` continuously high:**
  - `o_halted` = 1 after edge N+1.
  - `o_retired` includes the HALT after edge N+1.
- `i_enable` low for k cycles stretches latency by exactly k. Outputs stay stable throughout.
- `i_flush` acts only on the edge where `adv` is high.

## Test plan
- **Basic flow:** reset, then EX valid, wb=1, addr=5, alu=0x1234, mem_to_reg=0.
  - After edge 1: `o_ex_mem_wb`=1, `o_ex_mem_addr`=5.
  - After edge 2: `o_mem_wb_wb`=1, `o_mem_wb_addr`=5, `o_mem_wb_data`=0x1234, `o_retired`=1.
- **Load path:** mem_to_reg=1, mem_rd=1, `i_mem_rd_data`=0xCAFE while the entry is in EX/MEM.
  - After edge 2: `o_mem_wb_data`=0xCAFE; `o_ex_mem_mem_rd` was 1 during the MEM cycle.
- **r0 and flush:**
  - wb=1, addr=0 → `o_ex_mem_wb`=0 and `o_mem_wb_wb`=0.
  - Valid instruction with `i_flush`=1 → bubble; `o_retired` unchanged.
- **Stall:** `i_enable` low for 3 cycles with an entry in EX/MEM → all outputs unchanged. On re-enable, the entry reaches MEM/WB on the next edge.
- **Halt:** HALT, then two valid instructions.
  - `o_halted`=1 two edges after HALT enters.
  - `o_retired` = prior count + 1; the following instructions never reach MEM/WB.
  - Further clocks change nothing until reset.
- **Reset mid-operation:** assert `i_reset`=0 asynchronously between edges with both stages full → all outputs 0 immediately, and `o_halted`=0.
